// File: rtl/alu_serial_p.sv
// Bit-serial ALU: WIDTH-bit operands processed LSB-first through one
// full-adder/logic slice, with busy/done handshake and result hold.
module alu_serial_p #(
  parameter int WIDTH = 16,
  parameter int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [2:0]       op,
  output logic [WIDTH:0]   out,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_NEG  = 3'b111;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic             r_c;
  logic [WIDTH:0]   r_out;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;

  logic w_start;
  logic w_last;
  logic w_x;
  logic w_y;
  logic w_arith;
  logic w_lbit;
  logic w_sum;
  logic w_cout;
  logic w_bit;
  logic w_c0;

  assign out   = r_out;
  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_last  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (on) begin
          w_next  = S_RUN;
          w_start = 1'b1;
        end
      end
      S_RUN: begin
        if (r_count == CW'(WIDTH - 1)) begin
          w_next = S_IDLE;
          w_last = 1'b1;
        end
      end
    endcase
  end

  // Arithmetic ops map onto x + y + c with operand steering
  always_comb begin
    w_x     = r_a[0];
    w_y     = r_b[0];
    w_arith = 1'b0;
    w_lbit  = 1'b0;
    unique case (r_op)
      OP_ADD:  w_arith = 1'b1;
      OP_SUB: begin
        w_y     = ~r_b[0];
        w_arith = 1'b1;
      end
      OP_AND:  w_lbit = r_a[0] & r_b[0];
      OP_OR:   w_lbit = r_a[0] | r_b[0];
      OP_XOR:  w_lbit = r_a[0] ^ r_b[0];
      OP_XNOR: w_lbit = ~(r_a[0] ^ r_b[0]);
      OP_INC: begin
        w_y     = 1'b0;
        w_arith = 1'b1;
      end
      OP_NEG: begin
        w_x     = 1'b0;
        w_y     = ~r_a[0];
        w_arith = 1'b1;
      end
    endcase
    w_sum  = w_x ^ w_y ^ r_c;
    w_cout = (w_x & w_y) | (r_c & (w_x ^ w_y));
    w_bit  = w_arith ? w_sum : w_lbit;
  end

  assign w_c0 = (op == OP_SUB) || (op == OP_INC) || (op == OP_NEG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_c     <= 1'b0;
      r_out   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_a     <= ina;
        r_b     <= inb;
        r_op    <= op;
        r_c     <= w_c0;
        r_count <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= {w_bit, r_res[WIDTH-1:1]};
        r_c   <= w_cout;
        if (w_last) begin
          r_out   <= {w_arith & w_cout, w_bit, r_res[WIDTH-1:1]};
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_count <= '0;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_p.sv
// Bench for alu_serial_p: WIDTH=16 and WIDTH=5 instances,
// vector table plus scoreboard queues checked on done.
module tb_alu_serial_p;

  logic        clk;
  logic        rst;
  logic        on16;
  logic [15:0] ina16;
  logic [15:0] inb16;
  logic [2:0]  op16;
  logic [16:0] out16;
  logic [3:0]  count16;
  logic        busy16;
  logic        done16;

  logic        on5;
  logic [4:0]  ina5;
  logic [4:0]  inb5;
  logic [2:0]  op5;
  logic [5:0]  out5;
  logic [2:0]  count5;
  logic        busy5;
  logic        done5;

  int total;
  int bad;

  logic [16:0] q16[$];
  logic [5:0]  q5[$];
  logic [16:0] last16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [16:0] exp;
  } vec_t;

  vec_t tv[10];

  alu_serial_p #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .on(on16),
    .ina(ina16), .inb(inb16), .op(op16),
    .out(out16), .count(count16),
    .busy(busy16), .done(done16)
  );

  alu_serial_p #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .on(on5),
    .ina(ina5), .inb(inb5), .op(op5),
    .out(out5), .count(count5),
    .busy(busy5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [16:0] act,
                              logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        chk("q16_empty_on_done", 17'd1, 17'd0);
      end else begin
        logic [16:0] e;
        e = q16.pop_front();
        chk("out16", out16, e);
        last16 = e;
      end
    end
    if (done5) begin
      if (q5.size() == 0) begin
        chk("q5_empty_on_done", 17'd1, 17'd0);
      end else begin
        logic [5:0] e5;
        e5 = q5.pop_front();
        chk("out5", 17'(out5), 17'(e5));
      end
    end
  end

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] o, input logic [16:0] e);
    @(negedge clk);
    ina16 = a;
    inb16 = b;
    op16  = o;
    on16  = 1'b1;
    q16.push_back(e);
    @(negedge clk);
    on16 = 1'b0;
    chk("busy16_start", 17'(busy16), 17'd1);
    chk("count16_start", 17'(count16), 17'd0);
    ina16 = ~a;
    inb16 = ~b;
    op16  = ~o;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      chk("count16_run", 17'(count16), 17'(k));
      chk("busy16_run", 17'(busy16), 17'd1);
      chk("done16_run", 17'(done16), 17'd0);
      chk("out16_hold", out16, last16);
    end
    @(negedge clk);
    chk("done16_end", 17'(done16), 17'd1);
    chk("busy16_end", 17'(busy16), 17'd0);
    chk("count16_end", 17'(count16), 17'd0);
    @(negedge clk);
    chk("done16_pulse", 17'(done16), 17'd0);
  endtask

  task automatic run5(input logic [4:0] a, input logic [4:0] b,
                      input logic [2:0] o, input logic [5:0] e);
    @(negedge clk);
    ina5 = a;
    inb5 = b;
    op5  = o;
    on5  = 1'b1;
    q5.push_back(e);
    @(negedge clk);
    on5 = 1'b0;
    chk("count5_start", 17'(count5), 17'd0);
    chk("busy5_start", 17'(busy5), 17'd1);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("count5_run", 17'(count5), 17'(k));
      chk("done5_run", 17'(done5), 17'd0);
    end
    @(negedge clk);
    chk("done5_end", 17'(done5), 17'd1);
    chk("count5_end", 17'(count5), 17'd0);
    chk("busy5_end", 17'(busy5), 17'd0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    last16 = '0;
    rst    = 1'b1;
    on16   = 1'b0;
    ina16  = '0;
    inb16  = '0;
    op16   = '0;
    on5    = 1'b0;
    ina5   = '0;
    inb5   = '0;
    op5    = '0;

    tv[0] = '{16'h7003, 16'hC003, 3'b000, 17'h13006};
    tv[1] = '{16'h7003, 16'hC003, 3'b001, 17'h0B000};
    tv[2] = '{16'h0005, 16'h0003, 3'b001, 17'h10002};
    tv[3] = '{16'h7003, 16'hC003, 3'b010, 17'h04003};
    tv[4] = '{16'h7003, 16'hC003, 3'b011, 17'h0F003};
    tv[5] = '{16'h7003, 16'hC003, 3'b100, 17'h0B000};
    tv[6] = '{16'h7003, 16'hC003, 3'b101, 17'h04FFF};
    tv[7] = '{16'hFFFF, 16'h1234, 3'b110, 17'h10000};
    tv[8] = '{16'h0001, 16'hABCD, 3'b111, 17'h0FFFF};
    tv[9] = '{16'h0000, 16'h5555, 3'b111, 17'h10000};

    repeat (3) @(negedge clk);
    chk("rst_out16", out16, 17'd0);
    chk("rst_count16", 17'(count16), 17'd0);
    chk("rst_busy16", 17'(busy16), 17'd0);
    chk("rst_done16", 17'(done16), 17'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run16(tv[i].a, tv[i].b, tv[i].op, tv[i].exp);
    end

    // back-to-back: on held high, ina disturbed mid-run
    @(negedge clk);
    ina16 = 16'h0001;
    inb16 = 16'h0001;
    op16  = 3'b000;
    on16  = 1'b1;
    repeat (3) q16.push_back(17'h00002);
    for (int i = 0; i < 51; i++) begin
      @(negedge clk);
      chk("b2b_done", 17'(done16), 17'((i % 17) == 16));
      if (i == 5)  ina16 = 16'h00FF;
      if (i == 10) ina16 = 16'h0001;
      if (i == 50) on16 = 1'b0;
    end
    chk("b2b_out", out16, 17'h00002);

    // asynchronous reset in the middle of an ADD
    @(negedge clk);
    ina16 = 16'h7003;
    inb16 = 16'hC003;
    op16  = 3'b000;
    on16  = 1'b1;
    @(negedge clk);
    on16 = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_count16", 17'(count16), 17'd7);
    #2 rst = 1'b1;
    #1;
    chk("arst_out16", out16, 17'd0);
    chk("arst_count16", 17'(count16), 17'd0);
    chk("arst_busy16", 17'(busy16), 17'd0);
    chk("arst_done16", 17'(done16), 17'd0);
    @(negedge clk);
    rst = 1'b0;
    last16 = '0;
    run16(16'h0005, 16'h0003, 3'b000, 17'h00008);

    run5(5'h13, 5'h0E, 3'b000, 6'h21);
    run5(5'h13, 5'h0E, 3'b001, 6'h25);

    repeat (2) @(negedge clk);
    chk("q16_drained", 17'(q16.size()), 17'd0);
    chk("q5_drained", 17'(q5.size()), 17'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_serial_p.md
Name: alu_serial_p

Overview:
- Parametrised successor to the fixed 16-bit serial ALU.
- Processes WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder/logic slice.
- Adds asynchronous reset, busy/done handshake, result hold, and an 8-entry opcode set including INC and NEG.
- Sits next to the ring-oscillator clock source; the start pulse comes from the control sequencer.

Parameters:
- WIDTH, 16: operand width in bits; legal values are 2 to 64.
- CW, max(1,$clog2(WIDTH)): width of the bit counter.

Ports:
- clk  input  1  free-running clock (ring oscillator output).
- rst  input  1  asynchronous, active-high reset.
- on  input  1  start request, level-sampled on posedge clk.
- ina  input  WIDTH  operand A, sampled only at start.
- inb  input  WIDTH  operand B, sampled only at start.
- op  input  3  operation code, sampled only at start.
- out  output  WIDTH+1  result: [WIDTH-1:0] value, [WIDTH] carry flag.
- count  output  CW  index of the next bit to be processed.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when out is updated.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE; out, count, busy, done, internal shift registers and carry all 0. The operation in flight is discarded.
- States are IDLE and RUN.
- IDLE -> RUN when on=1 at a posedge (edge E):
  - latch ina, inb, op into shift registers;
  - preset carry: 1 for SUB, INC and NEG; 0 otherwise;
  - count=0, busy=1.
- RUN, edges E+1..E+WIDTH: each edge consumes bit[count] of A and B and shifts one result bit into the internal result register, MSB end first. count increments by 1.
- Edge E+WIDTH (final bit):
  - out <= {carry_out, result};
  - done=1 for exactly one cycle; busy=0; count=0; state=IDLE.
- Latency: start edge to done is WIDTH edges; throughput is one operation per WIDTH+1 cycles.
- out holds its previous result for the whole RUN; it changes only at the done edge or on reset.
- on=1 while in RUN is ignored, including on the final edge. on still high in IDLE on the following edge starts a new operation (back-to-back mode).
- Operand and op changes after edge E have no effect on the operation in flight.
- Ops, per bit (a=A bit, b=B bit, c=carry):
  - 000 ADD: a+b+c.
  - 001 SUB: a+~b+c, c0=1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 XNOR.
  - 110 INC: a+0+c, c0=1.
  - 111 NEG: 0+~a+c, c0=1.
- Carry flag:
  - out[WIDTH] = final adder carry for ADD, SUB, INC and NEG. For SUB, 1 means no borrow.
  - out[WIDTH] = 0 for the logic ops.
- count wraps only via the final-edge reset to 0, so it never exceeds WIDTH-1 for non-power-of-two WIDTH.

Test Plan:
- ADD, WIDTH=16, ina=16'h7003, inb=16'hC003, op=000, on pulsed for one edge -> busy high for 16 cycles, count 0..15. done one cycle after the 16th post-start edge; out=17'h13006.
- SUB with the same operands, op=001 -> out=17'h0B000 (carry 0 = borrow). SUB 16'h0005-16'h0003 -> out=17'h10002.
- AND / XOR / XNOR on 16'h7003 and 16'hC003 -> out=17'h04003 / 17'h0B000 / 17'h04FFF. Carry 0 in every case.
- INC 16'hFFFF -> 17'h10000. NEG 16'h0001 -> 17'h0FFFF. NEG 16'h0000 -> 17'h10000.
- Hold on=1 continuously with ADD 1+1 -> done pulses every 17 cycles; out=17'h00002 each time. Change ina mid-run -> current result unaffected.
- Assert rst at count=7 mid-ADD -> out, count, busy, done are 0 immediately (asynchronous). After release, a new op completes correctly.
- Repeat ADD/SUB with WIDTH=5 (ina=5'h13, inb=5'h0E) -> ADD out=6'h21, SUB out=6'h25. count runs 0..4 and returns to 0.
